hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core.
- Decides stage-register load enables, flushes and the controlmux select (zero = 1'b0, norm = 1'b1) for the ID/EX control bundle.
- Handles three hazard sources: load-use bubbles, I/D memory stalls, and branch-mispredict redirects, including a redirect that arrives during an outstanding fetch.
- Sits beside the forwarding unit; consumes decode/EX hazard info and cache stall lines, and drives the PC and pipeline registers.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stage-register enables, IF/ID flush,
// ID/EX control-mux select and PC redirect for load-use, memory-stall and mispredict hazards.
module hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_mispredict,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_load,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             controlmux_sel,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN,
        DISCARD
    } state_e;

    localparam logic SEL_ZERO = 1'b0;
    localparam logic SEL_NORM = 1'b1;

    state_e          state, next_state;
    logic [XLEN-1:0] target_q, target_d;
    logic            bubble_inc, flush_inc;
    logic            load_use;

    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                       (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state     = state;
        target_d       = target_q;
        bubble_inc     = 1'b0;
        flush_inc      = 1'b0;
        pc_load        = 1'b1;
        pc_redirect    = 1'b0;
        redirect_pc    = '0;
        if_id_load     = 1'b1;
        id_ex_load     = 1'b1;
        ex_mem_load    = 1'b1;
        mem_wb_load    = 1'b1;
        if_id_flush    = 1'b0;
        controlmux_sel = SEL_NORM;

        if (!rst) begin
            pc_load        = 1'b0;
            if_id_load     = 1'b0;
            id_ex_load     = 1'b0;
            ex_mem_load    = 1'b0;
            mem_wb_load    = 1'b0;
            controlmux_sel = SEL_ZERO;
        end else if (dmem_stall) begin
            // Whole pipe frozen; a pending mispredict stays valid in EX and is seen later.
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_mispredict) begin
                        flush_inc      = 1'b1;
                        controlmux_sel = SEL_ZERO;
                        if (imem_stall) begin
                            pc_load    = 1'b0;
                            if_id_load = 1'b0;
                            target_d   = ex_target;
                            next_state = DISCARD;
                        end else begin
                            pc_redirect = 1'b1;
                            redirect_pc = ex_target;
                            if_id_flush = 1'b1;
                        end
                    end else if (load_use || imem_stall) begin
                        pc_load        = 1'b0;
                        if_id_load     = 1'b0;
                        controlmux_sel = SEL_ZERO;
                        bubble_inc     = load_use;
                    end
                end
                DISCARD: begin
                    controlmux_sel = SEL_ZERO;
                    if (imem_stall) begin
                        pc_load    = 1'b0;
                        if_id_load = 1'b0;
                    end else begin
                        // The fetch that was in flight is stale: squash it as PC takes the target.
                        pc_redirect = 1'b1;
                        redirect_pc = target_q;
                        if_id_flush = 1'b1;
                        next_state  = RUN;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            target_q   <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            state    <= next_state;
            target_q <= target_d;
            if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against an action-level reference model.
module tb_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
    logic             if_id_use_rs1, if_id_use_rs2, id_ex_memread;
    logic             ex_mispredict, imem_stall, dmem_stall;
    logic [XLEN-1:0]  ex_target;
    logic             pc_load, pc_redirect, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic             if_id_flush, controlmux_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_load(pc_load), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .controlmux_sel(controlmux_sel),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed vector: {pc_load, pc_redirect, redirect_pc, if/id/ex/mem/wb loads, flush, sel, counters}
    logic [71:0] obs_now, obs, exp_v;
    assign obs_now = {pc_load, pc_redirect, redirect_pc, if_id_load, id_ex_load, ex_mem_load,
                      mem_wb_load, if_id_flush, controlmux_sel, bubble_cnt, flush_cnt};

    // Reference model: what the pipeline is doing this cycle, and what it remembers.
    typedef enum {A_RESET, A_FREEZE, A_REDIRECT, A_HOLD_FRONT, A_NORMAL} action_e;
    bit              m_discarding;
    logic [XLEN-1:0] m_target;
    int              m_bubbles, m_flushes;

    function automatic bit hazard_now();
        return id_ex_memread && id_ex_rd != 0 &&
               ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
    endfunction

    function automatic action_e decide(output logic [XLEN-1:0] tgt);
        tgt = '0;
        if (!rst) return A_RESET;
        if (dmem_stall) return A_FREEZE;
        if (m_discarding) begin
            tgt = m_target;
            return imem_stall ? A_HOLD_FRONT : A_REDIRECT;
        end
        if (ex_mispredict) begin
            tgt = ex_target;
            return imem_stall ? A_HOLD_FRONT : A_REDIRECT;
        end
        if (hazard_now() || imem_stall) return A_HOLD_FRONT;
        return A_NORMAL;
    endfunction

    function automatic logic [71:0] model_out();
        logic [XLEN-1:0] tgt;
        logic [15:0] b, f;
        action_e a = decide(tgt);
        b = 16'(m_bubbles);
        f = 16'(m_flushes);
        case (a)
            A_RESET:      return {1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0};
            A_FREEZE:     return {1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, b, f};
            A_REDIRECT:   return {1'b1, 1'b1, tgt,   4'b1111, 1'b1, 1'b0, b, f};
            A_HOLD_FRONT: return {1'b0, 1'b0, 32'h0, 4'b0111, 1'b0, 1'b0, b, f};
            default:      return {1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, b, f};
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_clear();
        m_discarding = 0;
        m_target     = '0;
        m_bubbles    = 0;
        m_flushes    = 0;
    endtask

    task automatic model_advance();
        logic [XLEN-1:0] tgt;
        action_e a = decide(tgt);
        if (a == A_RESET) begin
            model_clear();
        end else if (m_discarding) begin
            if (a == A_REDIRECT) m_discarding = 0;
        end else if (a == A_REDIRECT) begin
            m_flushes = sat_inc(m_flushes);
        end else if (a == A_HOLD_FRONT) begin
            if (ex_mispredict) begin
                m_flushes    = sat_inc(m_flushes);
                m_discarding = 1;
                m_target     = ex_target;
            end else if (hazard_now()) begin
                m_bubbles = sat_inc(m_bubbles);
            end
        end
    endtask

    // One cycle: inputs already driven; sample mid-cycle, then commit at the rising edge.
    task automatic step();
        if (!rst) model_clear();
        @(negedge clk);
        obs   = obs_now;
        exp_v = model_out();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        if_id_rs1 = 5'd1; if_id_rs2 = 5'd2; if_id_use_rs1 = 0; if_id_use_rs2 = 0;
        id_ex_memread = 0; id_ex_rd = 5'd0; ex_mispredict = 0; ex_target = '0;
        imem_stall = 0; dmem_stall = 0;
    endtask

    task automatic random_inputs();
        if_id_rs1     = 5'($urandom_range(0, 3));
        if_id_rs2     = 5'($urandom_range(0, 3));
        if_id_use_rs1 = 1'($urandom_range(0, 1));
        if_id_use_rs2 = 1'($urandom_range(0, 1));
        id_ex_memread = ($urandom_range(0, 2) == 0);
        id_ex_rd      = 5'($urandom_range(0, 3));
        ex_mispredict = ($urandom_range(0, 5) == 0);
        ex_target     = $urandom & 32'hFFFF_FFFC;
        imem_stall    = ($urandom_range(0, 3) == 0);
        dmem_stall    = ($urandom_range(0, 6) == 0);
    endtask

    task automatic test_reset();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            random_inputs();
            step();
            tests++;
            if (obs !== 72'h0 || exp_v !== 72'h0) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: got %h want 0", i, obs);
            end
        end
        idle_inputs();
        rst = 1;
        step();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_release_model: got %h want %h", obs, exp_v);
        end
        tests++;
        if ({obs[71], obs[37:34], obs[32]} !== 6'h3f || obs[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL reset_release: got %h want loads=1 sel=1 counters=0", obs);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_use_rs2 = 1;
        if_id_rs1 = 5'd3; if_id_use_rs1 = 1;
        step();
        tests++;
        if (obs !== exp_v || pc_load !== 1'b1 && 0) begin end
        if (obs !== exp_v || obs[71] !== 1'b0 || obs[37] !== 1'b0 || obs[32] !== 1'b0) begin
            fails++;
            $display("FAIL load_use_stall: got %h want %h", obs, exp_v);
        end
        idle_inputs();
        step();
        tests++;
        if (obs !== exp_v || obs[31:16] !== 16'd1 || obs[71] !== 1'b1) begin
            fails++;
            $display("FAIL load_use_one_bubble: got %h want %h (bubble_cnt 1)", obs, exp_v);
        end
        id_ex_memread = 1; id_ex_rd = 5'd0; if_id_rs2 = 5'd0; if_id_use_rs2 = 1;
        step();
        tests++;
        if (obs !== exp_v || obs[71] !== 1'b1 || obs[32] !== 1'b1) begin
            fails++;
            $display("FAIL load_use_rd0: got %h want %h (no stall)", obs, exp_v);
        end
    endtask

    task automatic test_mispredict_clean();
        idle_inputs();
        ex_mispredict = 1; ex_target = 32'h0000_1040;
        step();
        tests++;
        if (obs !== exp_v || obs[70] !== 1'b1 || obs[69:38] !== 32'h1040 || obs[33] !== 1'b1) begin
            fails++;
            $display("FAIL mispredict_clean: got %h want %h", obs, exp_v);
        end
        idle_inputs();
        step();
        tests++;
        if (obs !== exp_v || obs[15:0] !== 16'd1) begin
            fails++;
            $display("FAIL mispredict_clean_cnt: got %h want %h (flush_cnt 1)", obs, exp_v);
        end
    endtask

    task automatic test_mispredict_fetch();
        idle_inputs();
        ex_mispredict = 1; ex_target = 32'h2000; imem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (obs !== exp_v || obs[71] !== 1'b0 || obs[70] !== 1'b0 || obs[36:34] !== 3'b111) begin
                fails++;
                $display("FAIL discard_hold cyc%0d: got %h want %h", i, obs, exp_v);
            end
            // EX holds a bubble now; one stray mispredict must not replace the captured target.
            ex_mispredict = (i == 1);
            ex_target     = 32'h3000;
        end
        ex_mispredict = 0; imem_stall = 0;
        step();
        tests++;
        if (obs !== exp_v || obs[70] !== 1'b1 || obs[69:38] !== 32'h2000 || obs[33] !== 1'b1) begin
            fails++;
            $display("FAIL discard_redirect: got %h want %h", obs, exp_v);
        end
        step();
        tests++;
        if (obs !== exp_v || obs[71] !== 1'b1 || obs[70] !== 1'b0 || obs[15:0] !== 16'd2) begin
            fails++;
            $display("FAIL discard_back_to_run: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_dstall_priority();
        idle_inputs();
        ex_mispredict = 1; ex_target = 32'h4000; dmem_stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (obs !== exp_v || obs[71] !== 1'b0 || obs[37:34] !== 4'b0000 ||
                obs[32] !== 1'b1 || obs[15:0] !== 16'd2) begin
                fails++;
                $display("FAIL dstall_freeze cyc%0d: got %h want %h", i, obs, exp_v);
            end
        end
        dmem_stall = 0;
        step();
        tests++;
        if (obs !== exp_v || obs[70] !== 1'b1 || obs[69:38] !== 32'h4000) begin
            fails++;
            $display("FAIL dstall_release_redirect: got %h want %h", obs, exp_v);
        end
        idle_inputs();
        step();
        tests++;
        if (obs[15:0] !== 16'd3) begin
            fails++;
            $display("FAIL dstall_flush_cnt: got %0d want 3", obs[15:0]);
        end
    endtask

    task automatic test_reset_mid_discard();
        idle_inputs();
        ex_mispredict = 1; ex_target = 32'h5000; imem_stall = 1;
        step();
        ex_mispredict = 0;
        rst = 0;
        step();
        tests++;
        if (obs !== 72'h0) begin
            fails++;
            $display("FAIL reset_mid_discard: got %h want 0", obs);
        end
        rst = 1; imem_stall = 0;
        step();
        tests++;
        if (obs !== exp_v || obs[70] !== 1'b0 || obs[71] !== 1'b1) begin
            fails++;
            $display("FAIL reset_abandons_discard: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            rst = ($urandom_range(0, 199) != 0);
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                bad++;
                if (bad <= 10) $display("FAIL random cyc%0d: got %h want %h", i, obs, exp_v);
            end
        end
        rst = 1;
    endtask

    task automatic test_saturation();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
        id_ex_memread = 1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7; if_id_use_rs1 = 1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
        idle_inputs();
        step();
        tests++;
        if (obs !== exp_v || obs[31:16] !== 16'hFFFF) begin
            fails++;
            $display("FAIL bubble_saturate: got %h want %h (bubble_cnt ffff)", obs, exp_v);
        end
    endtask

    initial begin
        model_clear();
        idle_inputs();
        rst = 0;
        test_reset();
        test_load_use();
        test_mispredict_clean();
        test_mispredict_fetch();
        test_dstall_priority();
        test_reset_mid_discard();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
